// File: rtl/fb_dmem_ctrl.sv
// Data-memory responder for the MEM stage: request/grant/response on an SRAM-style bus with timeout.
// Optional feature: define FB_DMEM_POSTED_WR_EN to post aligned stores without stalling the pipeline.
module fb_dmem_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_vld,
  output logic              err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic                we_r;
  logic                rd_r;
  logic                err_r;
  logic                posted_r;
  logic [DATA_W-1:0]   rdata_r;
  logic [CNT_W-1:0]    cnt_r;

  logic                req_s;
  logic                aligned_s;
  logic                post_s;
  logic                tmo_s;
  logic                load_s;
  logic                cap_s;
  logic                zero_s;
  logic                tmo_err_s;
  logic                cnt_clr_s;
  logic                stall_s;

  assign req_s     = mem_read | mem_write;
  assign aligned_s = (addr[1:0] == 2'b00);
  assign tmo_s     = (cnt_r == CNT_W'(TIMEOUT - 1));

`ifdef FB_DMEM_POSTED_WR_EN
  assign post_s = mem_write & ~mem_read & aligned_s;
`else
  assign post_s = 1'b0;
`endif

  // Next-state logic; a grant or read data in the timeout cycle counts as progress.
  always_comb begin
    state_nxt = state_r;
    load_s    = 1'b0;
    cap_s     = 1'b0;
    zero_s    = 1'b0;
    tmo_err_s = 1'b0;
    cnt_clr_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          load_s = 1'b1;
          if (!aligned_s) begin
            state_nxt = DONE;
            zero_s    = mem_read;
          end else begin
            state_nxt = REQ;
            cnt_clr_s = 1'b1;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      REQ: begin
        if (bus_gnt) begin
          if (we_r) begin
            state_nxt = DONE;
          end else if (bus_rvalid) begin
            state_nxt = DONE;
            cap_s     = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_clr_s = 1'b1;
          end
        end else if (tmo_s) begin
          state_nxt = DONE;
          tmo_err_s = 1'b1;
          zero_s    = ~we_r;
        end else begin
          state_nxt = REQ;
        end
      end
      WAIT: begin
        if (bus_rvalid) begin
          state_nxt = DONE;
          cap_s     = 1'b1;
        end else if (tmo_s) begin
          state_nxt = DONE;
          tmo_err_s = 1'b1;
          zero_s    = 1'b1;
        end else begin
          state_nxt = WAIT;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and request latches; err_r records both-asserted or misaligned at accept time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      addr_r   <= {ADDR_W{1'b0}};
      wdata_r  <= {DATA_W{1'b0}};
      we_r     <= 1'b0;
      rd_r     <= 1'b0;
      err_r    <= 1'b0;
      posted_r <= 1'b0;
    end else begin
      state_r <= state_nxt;
      if (load_s) begin
        addr_r   <= addr;
        wdata_r  <= wdata;
        we_r     <= mem_write & ~mem_read;
        rd_r     <= mem_read;
        err_r    <= (mem_read & mem_write) | ~aligned_s;
        posted_r <= post_s;
      end else if (tmo_err_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Load data register: updated only on the edge into DONE, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= {DATA_W{1'b0}};
    end else if (cap_s) begin
      rdata_r <= bus_rdata;
    end else if (zero_s) begin
      rdata_r <= {DATA_W{1'b0}};
    end
  end

  // Timeout counter for REQ and WAIT; cleared on entry to either state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_clr_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == REQ) || (state_r == WAIT)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Pipeline hold; a posted store only stalls requests that arrive behind it.
  always_comb begin
    stall_s = 1'b0;
    case (state_r)
      IDLE:      stall_s = req_s & ~post_s;
      REQ, WAIT: stall_s = ~posted_r | req_s;
      DONE:      stall_s = posted_r & req_s;
      default:   stall_s = 1'b0;
    endcase
  end

  assign mem_stall = rst_n & stall_s;
  assign bus_req   = (state_r == REQ);
  assign bus_we    = we_r;
  assign bus_addr  = addr_r;
  assign bus_wdata = wdata_r;
  assign rdata     = rdata_r;
  assign rdata_vld = (state_r == DONE) & rd_r;
  assign err       = (state_r == DONE) & err_r;

endmodule
